// File: rtl/fft_addr_ctrl_pkg.sv
// Shared types and size helpers for the in-place radix-2 FFT address controller.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

    // Address width for an n-point transform.
    function automatic int unsigned addr_w(input int unsigned n);
        return $clog2(n);
    endfunction

    // Number of radix-2 stages for an n-point transform.
    function automatic int unsigned num_stages(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fft_addr_ctrl_if.sv
// Control/address bundle between the FFT sequencer and the cRAM/butterfly side.
interface fft_addr_ctrl_if
    import fft_pkg::*;
#(
    parameter int unsigned N = 16
) ();
    localparam int unsigned ADDR_W = addr_w(N);

    logic              start;
    logic              busy;
    logic              done;
    logic              sel;
    logic [ADDR_W-1:0] read_address1;
    logic [ADDR_W-1:0] read_address2;
    logic              rd_valid;
    logic [ADDR_W-2:0] tw_index;
    logic [ADDR_W-1:0] write_address1;
    logic [ADDR_W-1:0] write_address2;
    logic              wr_en;

    modport master (
        output start,
        input  busy, done, sel, read_address1, read_address2, rd_valid,
               tw_index, write_address1, write_address2, wr_en
    );

    modport slave (
        input  start,
        output busy, done, sel, read_address1, read_address2, rd_valid,
               tw_index, write_address1, write_address2, wr_en
    );
endinterface

// File: rtl/fft_addr_ctrl_delay_line.sv
// Fixed-depth register pipeline with synchronous clear; carries the write path.
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/fft_addr_ctrl.sv
// In-place radix-2 DIT FFT address sequencer: walks stages/butterflies, issues
// read pairs and twiddle index, and replays the pairs as writes after the datapath latency.
module fft_addr_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned BF_LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    fft_addr_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W = addr_w(N);
    localparam int unsigned L      = num_stages(N);
    localparam int unsigned B_W    = ADDR_W - 1;
    localparam int unsigned S_W    = (L > 2) ? $clog2(L) : 1;
    localparam int unsigned CNT_W  = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
    localparam int unsigned DL_W   = 1 + 2 * ADDR_W;

    localparam logic [B_W-1:0]   B_LAST   = B_W'(N / 2 - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(L - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BF_LATENCY - 1);

    fft_state_e        state_q, state_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [B_W-1:0]    b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] ra1_q, ra1_d;
    logic [ADDR_W-1:0] ra2_q, ra2_d;
    logic [B_W-1:0]    tw_q, tw_d;

    logic [B_W-1:0]    mask_w, pos_w, grp_w, tw_w;
    logic [ADDR_W-1:0] span_w, addr1_w;
    logic [DL_W-1:0]   wr_bus_w;

    // Next state, loop counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_READ;
                    s_d     = '0;
                    b_d     = '0;
                end
            end
            ST_READ: begin
                if (b_q == B_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    b_d = b_q + B_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                        s_d     = s_q + S_W'(1);
                        b_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        rd_valid_d = (state_d == ST_READ);
        busy_d     = (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
        ra1_d      = rd_valid_d ? addr1_w : '0;
        ra2_d      = rd_valid_d ? (addr1_w + span_w) : '0;
        tw_d       = rd_valid_d ? tw_w : '0;
    end

    // Butterfly b of stage s: group base plus offset within the span.
    always_comb begin
        mask_w  = ~({B_W{1'b1}} << s_d);
        pos_w   = b_d & mask_w;
        grp_w   = b_d >> s_d;
        span_w  = ADDR_W'(1) << s_d;
        addr1_w = (({1'b0, grp_w} << s_d) << 1) | {1'b0, pos_w};
        tw_w    = pos_w << (S_LAST - s_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            ra1_q      <= '0;
            ra2_q      <= '0;
            tw_q       <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            ra1_q      <= ra1_d;
            ra2_q      <= ra2_d;
            tw_q       <= tw_d;
        end
    end

    delay_line #(
        .WIDTH (DL_W),
        .DEPTH (BF_LATENCY)
    ) u_wr_delay (
        .clk (clk),
        .rst (rst),
        .d_i ({rd_valid_q, ra1_q, ra2_q}),
        .q_o (wr_bus_w)
    );

    assign bus.busy           = busy_q;
    assign bus.sel            = busy_q;
    assign bus.done           = done_q;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.read_address1  = ra1_q;
    assign bus.read_address2  = ra2_q;
    assign bus.tw_index       = tw_q;
    assign bus.wr_en          = wr_bus_w[DL_W-1];
    assign bus.write_address1 = wr_bus_w[2*ADDR_W-1:ADDR_W];
    assign bus.write_address2 = wr_bus_w[ADDR_W-1:0];
endmodule
